// File: rtl/hsv_pipe_ctrl.sv
// Flush/fill sequencer, threshold shadowing and sync-latency monitor for the
// RGB->HSV skin-detection pipeline.
module hsv_pipe_ctrl #(
    parameter int unsigned LATENCY   = 77,
    parameter logic [7:0]  H_MIN_RST = 8'd0,
    parameter logic [7:0]  H_MAX_RST = 8'd50,
    parameter logic [7:0]  S_MIN_RST = 8'd58,
    parameter logic [7:0]  S_MAX_RST = 8'd173,
    parameter logic [7:0]  V_MIN_RST = 8'd40,
    parameter logic [7:0]  V_MAX_RST = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pipe_de,
    input  logic        pipe_hsync,
    input  logic        pipe_vsync,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ack,
    output logic [7:0]  h_min,
    output logic [7:0]  h_max,
    output logic [7:0]  s_min,
    output logic [7:0]  s_max,
    output logic [7:0]  v_min,
    output logic [7:0]  v_max,
    output logic        out_valid,
    output logic [15:0] frame_cnt,
    output logic        sync_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        FLUSH      = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
    localparam logic [7:0] THR_RST [6] = '{H_MIN_RST, H_MAX_RST, S_MIN_RST,
                                           S_MAX_RST, V_MIN_RST, V_MAX_RST};

    state_t      state_q, state_d;
    logic [7:0]  fill_q, fill_d;
    logic        pvs_q, pvs_d;
    logic        vs_q, vs_d;
    logic [7:0]  lat_q, lat_d;
    logic        lat_run_q, lat_run_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        sync_err_q, sync_err_d;
    logic        cfg_ack_q, cfg_ack_d;
    logic [7:0]  stg_q [6];
    logic [7:0]  stg_d [6];
    logic [7:0]  act_q [6];
    logic [7:0]  act_d [6];

    logic pvs_rise, vs_rise, lat_ok, mismatch, commit;

    always_comb begin
        pvs_rise = ce & pipe_vsync & ~pvs_q;
        vs_rise  = ce & vsync_in & ~vs_q;
        // Counter reads LATENCY-1 in the cycle a correctly delayed edge arrives.
        lat_ok   = lat_run_q && (lat_q == LAT_M1);
        mismatch = pvs_rise && (state_q == RUN) && !lat_ok;
        commit   = pvs_rise && ((state_q == WAIT_FRAME) || ((state_q == RUN) && lat_ok));

        state_d     = state_q;
        fill_d      = fill_q;
        pvs_d       = pvs_q;
        vs_d        = vs_q;
        lat_d       = lat_q;
        lat_run_d   = lat_run_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;
        cfg_ack_d   = cfg_we;
        stg_d       = stg_q;
        act_d       = act_q;

        if (ce) begin
            pvs_d = pipe_vsync;
            vs_d  = vsync_in;
            if (vs_rise) begin
                lat_d     = '0;
                lat_run_d = 1'b1;
            end else if (pvs_rise) begin
                lat_run_d = 1'b0;
            end else if (lat_run_q && (lat_q != 8'hFF)) begin
                lat_d = lat_q + 8'd1;
            end

            unique case (state_q)
                FLUSH: begin
                    out_valid_d = 1'b0;
                    if (fill_q == LAT_M1) begin
                        state_d = WAIT_FRAME;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + 8'd1;
                    end
                end
                WAIT_FRAME: begin
                    out_valid_d = 1'b0;
                    if (pvs_rise) state_d = RUN;
                end
                RUN: begin
                    if (mismatch) begin
                        state_d     = FLUSH;
                        fill_d      = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = pipe_de;
                    end
                end
                default: state_d = FLUSH;
            endcase

            if (commit) begin
                act_d       = stg_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        // Staging and error clear run off the raw strobe; commit reads stg_q.
        if (cfg_we) begin
            case (cfg_addr)
                3'd0: stg_d[0] = cfg_data;
                3'd1: stg_d[1] = cfg_data;
                3'd2: stg_d[2] = cfg_data;
                3'd3: stg_d[3] = cfg_data;
                3'd4: stg_d[4] = cfg_data;
                3'd5: stg_d[5] = cfg_data;
                3'd7: sync_err_d = 1'b0;
                default: ;
            endcase
        end
        if (mismatch) sync_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FLUSH;
            fill_q      <= '0;
            pvs_q       <= 1'b0;
            vs_q        <= 1'b0;
            lat_q       <= '0;
            lat_run_q   <= 1'b0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            sync_err_q  <= 1'b0;
            cfg_ack_q   <= 1'b0;
            stg_q       <= THR_RST;
            act_q       <= THR_RST;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            pvs_q       <= pvs_d;
            vs_q        <= vs_d;
            lat_q       <= lat_d;
            lat_run_q   <= lat_run_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
            cfg_ack_q   <= cfg_ack_d;
            stg_q       <= stg_d;
            act_q       <= act_d;
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign h_min     = act_q[0];
    assign h_max     = act_q[1];
    assign s_min     = act_q[2];
    assign s_max     = act_q[3];
    assign v_min     = act_q[4];
    assign v_max     = act_q[5];
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign sync_err  = sync_err_q;
    assign state     = state_q;

    // Line-level timing is carried alongside but not needed for sequencing.
    logic unused_ok;
    assign unused_ok = &{1'b0, de_in, hsync_in, pipe_hsync};

endmodule

// File: tb/tb_hsv_pipe_ctrl.sv
// Directed bench for hsv_pipe_ctrl: fill sequencing, threshold shadowing,
// latency checking, ce gating and reset recovery.
module tb_hsv_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic        de_in, hsync_in, vsync_in;
    logic        pipe_de, pipe_hsync, pipe_vsync;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ack;
    logic [7:0]  h_min, h_max, s_min, s_max, v_min, v_max;
    logic        out_valid;
    logic [15:0] frame_cnt;
    logic        sync_err;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;
    bit toggle = 1'b0;

    always #5 clk = ~clk;

    hsv_pipe_ctrl #(.LATENCY(77)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pipe_de(pipe_de), .pipe_hsync(pipe_hsync), .pipe_vsync(pipe_vsync),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .h_min(h_min), .h_max(h_max), .s_min(s_min), .s_max(s_max),
        .v_min(v_min), .v_max(v_max),
        .out_valid(out_valid), .frame_cnt(frame_cnt), .sync_err(sync_err),
        .state(state)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One enabled cycle; in toggle mode it is preceded by a ce=0 cycle.
    task automatic tick();
        if (toggle) begin
            ce = 1'b0;
            step();
        end
        ce = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    // vsync_in pulse, then pipe_vsync rises lat enabled cycles later;
    // optionally a config write lands on the same edge as pipe_vsync.
    task automatic frame(input int lat, input bit wr, input logic [2:0] a, input logic [7:0] d);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        repeat (lat - 1) tick();
        pipe_vsync = 1'b1;
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        end
        tick();
        pipe_vsync = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic check_rst(input string p);
        check_val({p, "_state"}, 16'(state), 16'd0);
        check_val({p, "_valid"}, 16'(out_valid), 16'd0);
        check_val({p, "_ack"}, 16'(cfg_ack), 16'd0);
        check_val({p, "_fcnt"}, frame_cnt, 16'd0);
        check_val({p, "_serr"}, 16'(sync_err), 16'd0);
        check_val({p, "_hmin"}, 16'(h_min), 16'd0);
        check_val({p, "_hmax"}, 16'(h_max), 16'd50);
        check_val({p, "_smin"}, 16'(s_min), 16'd58);
        check_val({p, "_smax"}, 16'(s_max), 16'd173);
        check_val({p, "_vmin"}, 16'(v_min), 16'd40);
        check_val({p, "_vmax"}, 16'(v_max), 16'd255);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        pipe_de = 1'b0; pipe_hsync = 1'b0; pipe_vsync = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        step(); step();
        check_rst("por");
        rst = 1'b0;

        // Fill: 77 enabled cycles in FLUSH, then WAIT_FRAME until cycle 100
        repeat (76) tick();
        check_val("flush_76", 16'(state), 16'd0);
        tick();
        check_val("wait_77", 16'(state), 16'd1);
        pipe_de = 1'b1;
        repeat (22) tick();
        check_val("wait_99", 16'(state), 16'd1);
        check_val("wait_valid", 16'(out_valid), 16'd0);
        pipe_de = 1'b0;
        pipe_vsync = 1'b1;
        tick();
        pipe_vsync = 1'b0;
        check_val("run_state", 16'(state), 16'd2);
        check_val("run_fcnt", frame_cnt, 16'd1);
        pipe_de = 1'b1;
        tick();
        check_val("valid_hi", 16'(out_valid), 16'd1);
        pipe_de = 1'b0;
        tick();
        check_val("valid_lo", 16'(out_valid), 16'd0);

        // Mid-frame write is shadowed until the next frame edge
        cfg_write(3'd1, 8'd80);
        check_val("ack_hi", 16'(cfg_ack), 16'd1);
        check_val("hmax_held", 16'(h_max), 16'd50);
        tick();
        check_val("ack_lo", 16'(cfg_ack), 16'd0);
        frame(77, 1'b0, 3'd0, 8'd0);
        check_val("hmax_commit", 16'(h_max), 16'd80);
        check_val("f2_fcnt", frame_cnt, 16'd2);
        check_val("f2_serr", 16'(sync_err), 16'd0);
        check_val("f2_state", 16'(state), 16'd2);

        // Write coinciding with commit applies one frame later
        frame(77, 1'b1, 3'd2, 8'd10);
        check_val("smin_same", 16'(s_min), 16'd58);
        check_val("smin_ack", 16'(cfg_ack), 16'd1);
        check_val("f3_fcnt", frame_cnt, 16'd3);
        frame(77, 1'b0, 3'd0, 8'd0);
        check_val("smin_next", 16'(s_min), 16'd10);
        check_val("f4_fcnt", frame_cnt, 16'd4);

        // No-op address and a staged h_min that the failing frame must not commit
        cfg_write(3'd6, 8'hAA);
        check_val("nop_ack", 16'(cfg_ack), 16'd1);
        cfg_write(3'd0, 8'd5);
        pipe_de = 1'b1;
        tick();
        check_val("pre_err_valid", 16'(out_valid), 16'd1);
        frame(78, 1'b0, 3'd0, 8'd0);
        pipe_de = 1'b0;
        check_val("lat78_serr", 16'(sync_err), 16'd1);
        check_val("lat78_valid", 16'(out_valid), 16'd0);
        check_val("lat78_state", 16'(state), 16'd0);
        check_val("lat78_fcnt", frame_cnt, 16'd4);
        check_val("lat78_hmin", 16'(h_min), 16'd0);
        cfg_write(3'd7, 8'd0);
        check_val("serr_clr", 16'(sync_err), 16'd0);

        // ce toggling: FLUSH spans 154 clocks, latency counted in enabled cycles
        rst = 1'b1;
        #1;
        check_rst("async");
        step();
        toggle = 1'b1;
        rst = 1'b0;
        repeat (76) tick();
        ce = 1'b0;
        step();
        check_val("tog_153", 16'(state), 16'd0);
        ce = 1'b1;
        step();
        check_val("tog_154", 16'(state), 16'd1);
        pipe_vsync = 1'b1;
        tick();
        pipe_vsync = 1'b0;
        check_val("tog_run", 16'(state), 16'd2);
        check_val("tog_fcnt1", frame_cnt, 16'd1);
        frame(77, 1'b0, 3'd0, 8'd0);
        check_val("tog_lat_serr", 16'(sync_err), 16'd0);
        check_val("tog_lat_fcnt", frame_cnt, 16'd2);
        check_val("tog_lat_state", 16'(state), 16'd2);
        // Error set and clear on the same edge: set wins
        frame(76, 1'b1, 3'd7, 8'd0);
        check_val("setwin_serr", 16'(sync_err), 16'd1);
        check_val("setwin_state", 16'(state), 16'd0);
        check_val("setwin_fcnt", frame_cnt, 16'd2);
        toggle = 1'b0;

        // Reset during RUN discards staged h_min
        repeat (77) tick();
        check_val("refill_state", 16'(state), 16'd1);
        pipe_vsync = 1'b1;
        tick();
        pipe_vsync = 1'b0;
        check_val("rerun_state", 16'(state), 16'd2);
        check_val("rerun_fcnt", frame_cnt, 16'd3);
        check_val("sticky_serr", 16'(sync_err), 16'd1);
        cfg_write(3'd0, 8'd9);
        pipe_de = 1'b1;
        tick();
        check_val("rerun_valid", 16'(out_valid), 16'd1);
        rst = 1'b1;
        #1;
        check_rst("runrst");
        pipe_de = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (77) tick();
        pipe_vsync = 1'b1;
        tick();
        pipe_vsync = 1'b0;
        check_val("recov_state", 16'(state), 16'd2);
        check_val("recov_fcnt", frame_cnt, 16'd1);
        check_val("recov_hmin", 16'(h_min), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
